// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the register-bus sequencer.
package bus_seq_pkg;

    localparam int             SEL_W           = 4;
    localparam logic [SEL_W-1:0] SEL_NONE      = 4'b0000;
    localparam int             TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        READ_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_e;

endpackage

// File: rtl/bus_sequencer_exec_timer.sv
// EXEC wait counter: cleared on EXEC entry, flags expiry at count TIMEOUT-1.
module exec_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == LAST);

    // Saturates at LAST so a stalled EXEC can never wrap back below expiry.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Register A/B/C bus initiator: sequences each micro-op as read, ALU execute, write-back.
module bus_sequencer #(
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = bus_seq_pkg::TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_W-1:0]      req_a_sel,
    input  logic [SEL_W-1:0]      req_b_sel,
    input  logic [SEL_W-1:0]      req_c_sel,
    output logic [SEL_W-1:0]      a_en,
    output logic [SEL_W-1:0]      b_en,
    output logic [SEL_W-1:0]      c_en,
    output logic                  alu_start,
    input  logic                  alu_done,
    output logic                  done,
    output logic                  err,
    output bus_seq_pkg::state_e   dbg_state
);

    import bus_seq_pkg::*;

    localparam logic [SEL_W-1:0] SEL_Z = SEL_W'(SEL_NONE);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] a_sel_q, a_sel_d;
    logic [SEL_W-1:0] b_sel_q, b_sel_d;
    logic [SEL_W-1:0] c_sel_q, c_sel_d;
    logic [SEL_W-1:0] a_en_q, a_en_d;
    logic [SEL_W-1:0] b_en_q, b_en_d;
    logic [SEL_W-1:0] c_en_q, c_en_d;
    logic             alu_start_q, alu_start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             split_q;
    logic             split_d;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expired;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and req_* are sampled only at that edge.
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // A register with matching A and B enables drives only A, so equal selects need two reads.
    assign split_q = (a_sel_q == b_sel_q) && (a_sel_q != SEL_Z);
    assign split_d = (a_sel_d == b_sel_d) && (a_sel_d != SEL_Z);

    assign a_en      = a_en_q;
    assign b_en      = b_en_q;
    assign c_en      = c_en_q;
    assign alu_start = alu_start_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    exec_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .RST     (RST),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            a_sel_q     <= '0;
            b_sel_q     <= '0;
            c_sel_q     <= '0;
            a_en_q      <= '0;
            b_en_q      <= '0;
            c_en_q      <= '0;
            alu_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            c_sel_q     <= c_sel_d;
            a_en_q      <= a_en_d;
            b_en_q      <= b_en_d;
            c_en_q      <= c_en_d;
            alu_start_q <= alu_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((req_a_sel == SEL_Z) && (req_b_sel == SEL_Z)) begin
                        state_d = EXEC;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = split_q ? READ_B : EXEC;
            end
            READ_B: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (alu_done) begin
                    state_d = (c_sel_q != SEL_Z) ? WRITE : IDLE;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        a_sel_d = a_sel_q;
        b_sel_d = b_sel_q;
        c_sel_d = c_sel_q;
        if (accept) begin
            a_sel_d = req_a_sel;
            b_sel_d = req_b_sel;
            c_sel_d = req_c_sel;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        a_en_d      = '0;
        b_en_d      = '0;
        c_en_d      = '0;
        alu_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state_d)
            READ: begin
                a_en_d = a_sel_d;
                b_en_d = split_d ? SEL_Z : b_sel_d;
            end
            READ_B: begin
                b_en_d = b_sel_d;
            end
            WRITE: begin
                c_en_d = c_sel_d;
            end
            default: begin
            end
        endcase

        alu_start_d = (state_d == EXEC) && (state_q != EXEC);
        tmr_clr     = alu_start_d;
        tmr_en      = (state_q == EXEC);

        done_d = (state_q == WRITE)
              || ((state_q == EXEC) && alu_done && (c_sel_q == SEL_Z));
        err_d  = (state_q == EXEC) && !alu_done && tmr_expired;
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scenario bench for bus_sequencer: per-cycle expected bus traces are queued at stimulus time.
module tb_bus_sequencer;

  localparam int W  = 16;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       RST;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a_sel, req_b_sel, req_c_sel;
  logic [3:0] a_en, b_en, c_en;
  logic       alu_start, alu_done, done, err;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  logic         ad_q[$];
  logic         rs_q[$];

  int n_vec = 0;
  int n_err = 0;

  bus_sequencer #(
    .SEL_W   (4),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a_sel (req_a_sel),
    .req_b_sel (req_b_sel),
    .req_c_sel (req_c_sel),
    .a_en      (a_en),
    .b_en      (b_en),
    .c_en      (c_en),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [W-1:0] vec(input logic rdy, input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic st, input logic dn,
                                       input logic er);
    return {rdy, a, b, c, st, dn, er};
  endfunction

  function automatic void push_cyc(input logic [W-1:0] e, input logic ad, input logic rs);
    exp_q.push_back(e);
    ad_q.push_back(ad);
    rs_q.push_back(rs);
  endfunction

  // Expected trace of one micro-op, starting with the cycle after the accepting edge.
  function automatic int push_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                 input int wait_n, input bit to, input bit stray);
    int n;
    int ne;
    n = 0;
    if (a != 4'd0 || b != 4'd0) begin
      push_cyc(vec(1'b0, a, (a == b) ? 4'd0 : b, 4'd0, 1'b0, 1'b0, 1'b0), stray, 1'b0);
      n++;
      if (a == b) begin
        push_cyc(vec(1'b0, 4'd0, b, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
        n++;
      end
    end
    ne = to ? TO : wait_n + 1;
    for (int k = 0; k < ne; k++) begin
      push_cyc(vec(1'b0, 4'd0, 4'd0, 4'd0, (k == 0), 1'b0, 1'b0), (!to && k == wait_n), 1'b0);
      n++;
    end
    if (!to && c != 4'd0) begin
      push_cyc(vec(1'b0, 4'd0, 4'd0, c, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
      n++;
    end
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, !to, to), 1'b0, 1'b0);
    n++;
    return n;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    req_valid = 1'b1;
    req_a_sel = a;
    req_b_sel = b;
    req_c_sel = c;
  endtask

  task automatic scramble();
    req_a_sel = 4'($urandom_range(0, 15));
    req_b_sel = 4'($urandom_range(0, 15));
    req_c_sel = 4'($urandom_range(0, 15));
  endtask

  // scoreboard: pop one expected cycle, apply its inputs, compare mid-cycle
  task automatic check_cycle(input string nm);
    logic [W-1:0] e;
    logic [W-1:0] act;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got 0 entries want at least 1", nm);
      tick();
    end else begin
      e        = exp_q.pop_front();
      alu_done = ad_q.pop_front();
      RST      = rs_q.pop_front();
      @(negedge clk);
      act = {req_ready, a_en, b_en, c_en, alu_start, done, err};
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got rdy=%b a=%h b=%h c=%h st=%b dn=%b er=%b, want rdy=%b a=%h b=%h c=%h st=%b dn=%b er=%b",
                 nm, act[15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                 e[15], e[14:11], e[10:7], e[6:3], e[2], e[1], e[0]);
      end
      tick();
    end
  endtask

  task automatic run_trace(input string nm, input int n);
    for (int i = 0; i < n; i++) check_cycle(nm);
  endtask

  task automatic idle_after();
    alu_done = 1'b0;
    RST      = 1'b0;
  endtask

  task automatic single_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input int wait_n, input bit to);
    int n;
    drive_req(a, b, c);
    n = push_op(a, b, c, wait_n, to, 1'b0);
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    scramble();
    run_trace(nm, n + 1);
    idle_after();
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    alu_done  = 1'b1;
    drive_req(4'd3, 4'd5, 4'd7);
    tick();
    tick();
    @(negedge clk);
    n_vec++;
    if ({req_ready, a_en, b_en, c_en, alu_start, done, err} !== vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b a=%h b=%h c=%h st=%b dn=%b er=%b, want rdy=1 others 0",
               req_ready, a_en, b_en, c_en, alu_start, done, err);
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    tick();
    RST       = 1'b0;
    req_valid = 1'b0;
    alu_done  = 1'b0;
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    run_trace("reset_idle", 2);
    idle_after();
  endtask

  task automatic test_basic();
    single_op("basic", 4'd3, 4'd5, 4'd7, 0, 1'b0);
  endtask

  task automatic test_split();
    single_op("split", 4'd4, 4'd4, 4'd4, 0, 1'b0);
  endtask

  task automatic test_skips();
    single_op("skip_all", 4'd0, 4'd0, 4'd0, 0, 1'b0);
    single_op("skip_a", 4'd0, 4'd7, 4'd0, 1, 1'b0);
    single_op("skip_write", 4'd2, 4'd9, 4'd0, 2, 1'b0);
  endtask

  task automatic test_timeout();
    single_op("timeout", 4'd1, 4'd2, 4'd5, 0, 1'b1);
    single_op("after_timeout", 4'd8, 4'd9, 4'd10, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_req(4'd2, 4'd0, 4'd9);
    push_cyc(vec(1'b0, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    push_cyc(vec(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
    push_cyc(vec(1'b0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    scramble();
    run_trace("reset_mid", 5);
    idle_after();
    single_op("after_reset", 4'd6, 4'd1, 4'd2, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n1;
    int n2;
    drive_req(4'd1, 4'd2, 4'd3);
    n1 = push_op(4'd1, 4'd2, 4'd3, 1, 1'b0, 1'b1);
    n2 = push_op(4'd6, 4'd6, 4'd0, 0, 1'b0, 1'b0);
    push_cyc(vec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    tick();
    drive_req(4'd6, 4'd6, 4'd0);
    run_trace("b2b_first", n1);
    req_valid = 1'b0;
    scramble();
    run_trace("b2b_second", n2 + 1);
    idle_after();
  endtask

  task automatic test_random();
    logic [3:0] a, b, c;
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      single_op("random", a, b, c, $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    req_a_sel = 4'd0;
    req_b_sel = 4'd0;
    req_c_sel = 4'd0;
    alu_done  = 1'b0;
    test_reset();
    test_basic();
    test_split();
    test_skips();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

- Control-side initiator for the processor's register A/B/C buses.
- Accepts one register-transfer micro-op per handshake and drives the 4-bit register-ID enable buses (`a_en`, `b_en`, `c_en`) that every general-purpose register compares against its own ID.
- Sequences each micro-op as read, then ALU execute, then write-back, so a register is never selected on A and B in the same cycle.
- Sits between the instruction decoder and the register file/ALU datapath.

## Interface
Parameters:
- `SEL_W`, 4: width of a register-ID select code.
- `TIMEOUT`, 16: maximum cycles spent in EXEC waiting for `alu_done`.

Ports:
- `clk`  in  1: clock, all logic on rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: micro-op request valid.
- `req_ready`  out  1: sequencer can accept a request.
- `req_a_sel`  in  SEL_W: register ID to drive onto the A bus.
- `req_b_sel`  in  SEL_W: register ID to drive onto the B bus.
- `req_c_sel`  in  SEL_W: register ID to write from the C bus.
- `a_en`  out  SEL_W: A-bus select, registered.
- `b_en`  out  SEL_W: B-bus select, registered.
- `c_en`  out  SEL_W: C-bus write select, registered.
- `alu_start`  out  1: one-cycle pulse, operands are valid.
- `alu_done`  in  1: ALU result is valid on the C bus.
- `done`  out  1: one-cycle pulse, micro-op completed.
- `err`  out  1: one-cycle pulse, micro-op aborted by timeout.

## Operation
- Select code 0 (`SEL_NONE`) means no register. Register IDs are 1..15.
- A select of 0 means that bus phase is skipped.
- States: IDLE, READ, READ_B, EXEC, WRITE.
- **IDLE**
  - `req_ready`=1 and all enables are 0.
  - On `req_valid` & `req_ready`, latch the three selects.
  - If both `a_sel` and `b_sel` are 0, go to EXEC.
  - Otherwise go to READ.
- **READ**
  - Drive `a_en`=`a_sel`.
  - If `a_sel`≠`b_sel`, also drive `b_en`=`b_sel`, then go to EXEC.
  - If `a_sel`=`b_sel`≠0, drive `b_en`=0, then go to READ_B.
- **READ_B**
  - Drive `b_en`=`b_sel` and `a_en`=0, then go to EXEC.
  - This state exists because a register outputs only on A when both its A and B enables match.
- **EXEC**
  - All enables are 0. `alu_start` pulses during the first EXEC cycle only.
  - A wait counter starts at 0 on entry and increments each EXEC cycle.
  - `alu_done`=1 is sampled at each edge; it is legal in the first EXEC cycle.
  - On `alu_done`: go to WRITE if `c_sel`≠0. If `c_sel`=0, go to IDLE and pulse `done`.
  - If the counter reaches TIMEOUT-1 without `alu_done`: go to IDLE, pulse `err`, perform no write and no `done`.
- **WRITE**
  - Drive `c_en`=`c_sel` for exactly one cycle, then go to IDLE and pulse `done`.
- `req_ready` is 0 in every state except IDLE.
  - A request held during a busy period is accepted in the first IDLE cycle.
  - There is no same-cycle accept on completion.
- `req_*` inputs are sampled only at the accepting edge. Later changes are ignored.
- `alu_done` outside EXEC is ignored.

## Timing
- Reset value of all outputs is 0, except `req_ready`=1; state is IDLE.
- Registered outputs (`a_en`, `b_en`, `c_en`, `alu_start`, `done`, `err`) change only at clock edges and are glitch-free.
- Edge E0 accepts the request; READ enables are visible in cycle E0→E1.
- Registers capture onto A/B at E1. Operand data is valid in cycle E1→E2, which is the cycle with `alu_start`=1.
- Minimum latency with `alu_done` in the first EXEC cycle and a write:
  - READ, EXEC, WRITE = 3 cycles.
  - `done` is high in the 4th cycle after E0.
  - `req_ready` returns in that same cycle.
- Each extra condition adds one cycle: the READ_B split, and each EXEC wait cycle.
- Each skipped phase removes one cycle: READ when both selects are 0, and WRITE when `c_sel`=0.
- `RST` mid-operation takes effect at the next edge:
  - State goes to IDLE and all enables go to 0 immediately.
  - No `done` or `err` is produced.
  - The aborted micro-op is lost.
- `RST` has priority over a simultaneous `req_valid` and over `alu_done`.

## Structure
- Package `bus_seq_pkg` holds:
  - the state enum (IDLE, READ, READ_B, EXEC, WRITE);
  - `SEL_W` = 4;
  - `SEL_NONE` = 4'b0000;
  - `TIMEOUT_DEFAULT` = 16.
- One sub-module, `exec_timer`: a clear/enable counter that raises an expired flag at count TIMEOUT-1. It is cleared on EXEC entry.
- The FSM and the output registers stay in `bus_sequencer`.

## Test plan
- **Basic op**
  - Stimulus: reset, then request a=3, b=5, c=7, with `alu_done` in the first EXEC cycle.
  - Required: `a_en`=3 and `b_en`=5 for one cycle; `alu_start` next cycle; `c_en`=7 next cycle; `done` next cycle; `req_ready` low for exactly 3 cycles.
- **Same-register split**
  - Stimulus: a=4, b=4, c=4.
  - Required: a cycle with `a_en`=4, `b_en`=0, then a cycle with `a_en`=0, `b_en`=4; no cycle has both nonzero; `done` arrives 1 cycle later than in the basic op.
- **Skips**
  - Stimulus: a=0, b=0, c=0.
  - Required: EXEC is entered directly; `alu_start` is in the cycle after accept; `done` follows `alu_done` with no `c_en` activity.
- **Timeout**
  - Stimulus: TIMEOUT=4, `alu_done` held 0.
  - Required: `err` pulses after 4 EXEC cycles; `c_en` stays 0; no `done`; the next request is accepted normally.
- **Reset mid-op**
  - Stimulus: assert `RST` during WRITE with c=9.
  - Required: `c_en` is 0 at the next edge; no `done`; `req_ready`=1.
- **Back-to-back**
  - Stimulus: `req_valid` held high with two different requests, and a stray `alu_done` pulse injected during READ.
  - Required: the second request is accepted in the `done` cycle; both complete in order; the stray `alu_done` is ignored.
